// File: rtl/button_debouncer.sv
// Pushbutton debouncer: 2-flop synchronizer followed by a four-state qualification FSM.
// btn_out changes only after STABLE_CYCLES consecutive synchronized samples at the new level.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_out,
  output logic [1:0] state
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sync1, btn_s;
  logic          out_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_in;
      btn_s <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= LOW;
      cnt     <= '0;
      btn_out <= 1'b0;
    end else begin
      cur     <= nxt;
      cnt     <= cnt_nxt;
      btn_out <= out_nxt;
    end
  end

  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    case (cur)
      LOW: begin
        cnt_nxt = '0;
        if (btn_s) begin
          nxt     = WAIT_HIGH;
          cnt_nxt = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!btn_s) begin
          nxt     = LOW;
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          nxt     = HIGH;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        cnt_nxt = '0;
        if (!btn_s) begin
          nxt     = WAIT_LOW;
          cnt_nxt = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (btn_s) begin
          nxt     = HIGH;
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          nxt     = LOW;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        nxt     = LOW;
        cnt_nxt = '0;
      end
    endcase
  end

  // Output is decoded from the next state so btn_out flips on the same edge as the state.
  assign out_nxt = (nxt == HIGH) || (nxt == WAIT_LOW);
  assign state   = cur;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4; expected state/level
// pairs are queued when stimulus is applied and checked after each clock edge.
module tb_button_debouncer;

  localparam int unsigned SC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       btn_out;
  logic [1:0] state;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       o;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] seq[$];
  int         n_assert = 0;
  int         n_fail   = 0;

  button_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_in  (btn_in),
    .btn_out (btn_out),
    .state   (state)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [1:0] st);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.o   = (st == 2'd2) || (st == 2'd3);
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    n_assert++;
    assert (state === e.st) else begin
      n_fail++;
      $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
    end
    n_assert++;
    assert (btn_out === e.o) else begin
      n_fail++;
      $error("FAIL %s btn_out: got %0b expected %0b", e.tag, btn_out, e.o);
    end
  endtask

  // One clock edge, then compare 1 time unit later.
  task automatic tick(input string tag, input logic [1:0] st);
    push(tag, st);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic run_seq(input string tag);
    foreach (seq[i]) tick($sformatf("%s_e%0d", tag, i), seq[i]);
  endtask

  task automatic check_now(input string tag, input logic [1:0] st);
    push(tag, st);
    compare();
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b1;
    #1;
    check_now("rst_async", 2'd0);
    for (int i = 0; i < 3; i++) tick($sformatf("rst_hold%0d", i), 2'd0);

    // release with btn_in already high: edge 0 is the first edge after release
    reset = 1'b0;
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    run_seq("press");

    btn_in = 1'b0;
    tick("glitch_e0", 2'd2);
    btn_in = 1'b1;
    seq = '{2'd2, 2'd3, 2'd2, 2'd2};
    run_seq("glitch");

    // low pulse of SC-1 samples must not get through
    btn_in = 1'b0;
    tick("short_e0", 2'd2);
    tick("short_e1", 2'd2);
    tick("short_e2", 2'd3);
    btn_in = 1'b1;
    seq = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd2};
    run_seq("short");

    btn_in = 1'b0;
    seq = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    run_seq("release");

    btn_in = 1'b1;
    tick("bounce_e0", 2'd0);
    tick("bounce_e1", 2'd0);
    btn_in = 1'b0;
    tick("bounce_e2", 2'd1);
    btn_in = 1'b1;
    tick("bounce_e3", 2'd1);
    btn_in = 1'b0;
    tick("bounce_e4", 2'd0);
    btn_in = 1'b1;
    seq = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    run_seq("bounce_tail");

    btn_in = 1'b0;
    seq = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    run_seq("release2");

    btn_in = 1'b1;
    seq = '{2'd0, 2'd0, 2'd1};
    run_seq("pre_rst");
    #3;
    reset = 1'b1;
    #1;
    check_now("rst_in_wait", 2'd0);
    tick("rst_in_wait_hold", 2'd0);
    reset = 1'b0;
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    run_seq("after_rst");

    #3;
    reset = 1'b1;
    #1;
    check_now("rst_in_high", 2'd0);
    tick("rst_in_high_hold", 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
